// File: rtl/axis_rx_fifo.sv
// First-word-fall-through AXI-Stream FIFO between the UART receive stream and
// the byte-to-word adapter, with occupancy and almost-full status.
module axis_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  tready_q, tready_d;
  logic                  tvalid_q, tvalid_d;
  logic                  push, pop;

  // Handshakes use only registered flags, so tready never depends on inputs.
  always_comb begin
    push     = s_axis_tvalid && tready_q;
    pop      = tvalid_q && m_axis_tready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    tready_d = !(count_d == CW'(DEPTH));
    tvalid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tready_q <= tready_d;
      tvalid_q <= tvalid_d;
    end
  end

  // Storage is deliberately not reset; stale entries are unreachable after rst.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = mem_q[rd_ptr_q];
  assign count         = count_q;
  assign almost_full   = (count_q >= CW'(AFULL_LEVEL));
  assign full          = (count_q == CW'(DEPTH));
  assign empty         = (count_q == '0);

endmodule

// File: tb/tb_axis_rx_fifo.sv
// Scoreboard bench for axis_rx_fifo: accepted beats are queued by the driver,
// and an independent negedge monitor checks every beat leaving the master port.
module tb_axis_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [4:0]    count;
  logic          almost_full;
  logic          full;
  logic          empty;

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] exp_q [$];
  logic          hold_q = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic          stress_done;
  int            vduty, rduty;

  axis_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .count         (count),
    .almost_full   (almost_full),
    .full          (full),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Output monitor: pops the scoreboard on each master handshake and checks
  // that a stalled head beat stays valid and unchanged.
  always @(negedge clk) begin
    logic [DW-1:0] exp_b;
    if (rst) begin
      hold_q <= 1'b0;
    end else begin
      check("count_bound", 32'(count <= 5'(DEPTH)), 32'd1);
      if (hold_q) begin
        check("head_valid_hold", 32'(m_axis_tvalid), 32'd1);
        check("head_data_hold", 32'(m_axis_tdata), 32'(held_data));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat actual=0x%0h required=none", m_axis_tdata);
        end else begin
          exp_b = exp_q.pop_front();
          check("out_data", 32'(m_axis_tdata), 32'(exp_b));
        end
      end
      hold_q    <= m_axis_tvalid && !m_axis_tready;
      held_data <= m_axis_tdata;
    end
  end

  // Drives one beat from posedge+1 and returns at posedge+1 after it is taken.
  task automatic send(input logic [DW-1:0] d);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", 32'(s_axis_tready), 32'd1);
    if (s_axis_tready) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!empty && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(empty), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    stress_done   = 1'b0;

    // Reset held for three edges.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_tready", 32'(s_axis_tready), 32'd0);
      check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_tready", 32'(s_axis_tready), 32'd1);
    check("post_rst_count", 32'(count), 32'd0);
    $display("[TB] reset/idle done");

    // Single beat latency.
    send(8'hA5);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    check("single_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("single_tdata", 32'(m_axis_tdata), 32'hA5);
    check("single_count", 32'(count), 32'd1);
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b0;
    @(negedge clk);
    check("single_pop_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("single_pop_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    $display("[TB] single beat 0xA5 done");

    // Fill to full, hold a 17th beat, then drain.
    for (int i = 0; i < DEPTH; i++) begin
      send(8'(i));
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_afull", 32'(almost_full), 32'((i + 1) >= AFULL));
      check("fill_full", 32'(full), 32'((i + 1) == DEPTH));
    end
    s_axis_tdata = 8'h10;
    check("full_tready", 32'(s_axis_tready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("full_hold_count", 32'(count), 32'd16);
      check("full_hold_tready", 32'(s_axis_tready), 32'd0);
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("full_pop_tready_before", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #1;
    check("full_pop_tready_after", 32'(s_axis_tready), 32'd1);
    check("full_pop_count", 32'(count), 32'd15);
    send(8'h10);
    s_axis_tvalid = 1'b0;
    wait_empty("fill_drain_empty");
    m_axis_tready = 1'b0;
    $display("[TB] fill/drain done");

    // Simultaneous push and pop at constant occupancy.
    for (int i = 0; i < 5; i++) send(8'h20 + 8'(i));
    m_axis_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(8'h30 + 8'(i));
      check("pushpop_count", 32'(count), 32'd5);
    end
    s_axis_tvalid = 1'b0;
    wait_empty("pushpop_drain_empty");
    m_axis_tready = 1'b0;
    $display("[TB] simultaneous push/pop done");

    // Random duty wrap-around stress.
    vduty = 30 + int'($urandom_range(60));
    rduty = 30 + int'($urandom_range(60));
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          while (int'($urandom_range(99)) >= vduty) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(8'($urandom_range(255)));
        end
        s_axis_tvalid = 1'b0;
        stress_done   = 1'b1;
      end
      begin
        while (!stress_done) begin
          m_axis_tready = (int'($urandom_range(99)) < rduty);
          @(posedge clk);
          #1;
        end
      end
    join
    m_axis_tready = 1'b1;
    wait_empty("stress_drain_empty");
    m_axis_tready = 1'b0;
    $display("[TB] stress vduty=%0d rduty=%0d done", vduty, rduty);

    // Reset while pushing and popping with nine beats buffered.
    for (int i = 0; i < 9; i++) send(8'h50 + 8'(i));
    check("pre_rst_count", 32'(count), 32'd9);
    s_axis_tdata  = 8'h77;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    exp_q.delete();
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    send(8'h3C);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    check("midrst_head", 32'(m_axis_tdata), 32'h3C);
    check("midrst_head_count", 32'(count), 32'd1);
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    wait_empty("midrst_drain_empty");
    m_axis_tready = 1'b0;
    $display("[TB] reset mid-operation done");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
